w5500_frame_ctrl: RTL and testbench

Request-level front end for the W5500 SPI path, sitting directly upstream of the TX FIFO and downstream of the RX FIFO that feed `spi_interface`. It turns one register/buffer access request (address, block select, direction, length) into a W5500 variable-length frame, then starts `spi_interface` through `work`/`op`/`len`. For reads it strips the 3 header echo bytes from the RX stream and forwards the payload bytes on a valid/ready port.

---
 rtl/w5500_pkg.sv | 34 +++
 rtl/w5500_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_w5500_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/w5500_pkg.sv
// rtl/w5500_pkg.sv - shared states, framing constants and control-byte helper for the W5500 front end
package w5500_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HDR,
    ST_PAY,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int         HDR_BYTES    = 3;
  localparam logic [1:0] OM_VDM       = 2'b00;
  localparam logic       OP_WRITE     = 1'b1;
  localparam logic       OP_READ      = 1'b0;
  localparam int         CTRL_BSB_LSB = 3;
  localparam int         CTRL_RWB_BIT = 2;
  localparam int         CTRL_OM_LSB  = 0;

  // Third header byte: BSB[4:0] | RWB | OM[1:0]
  function automatic logic [7:0] ctrl_byte(input logic [4:0] bsb, input logic write);
    logic [7:0] c;
    c = '0;
    c[CTRL_BSB_LSB +: 5] = bsb;
    c[CTRL_RWB_BIT]      = write;
    c[CTRL_OM_LSB +: 2]  = OM_VDM;
    return c;
  endfunction

endpackage

// File: rtl/w5500_frame_ctrl.sv
// rtl/w5500_frame_ctrl.sv - turns one register/buffer request into a W5500 frame and strips the RX echo
module w5500_frame_ctrl
  import w5500_pkg::*;
#(
  parameter int DATA       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [15:0]     req_addr,
  input  logic [4:0]      req_bsb,
  input  logic            req_write,
  input  logic [15:0]     req_len,
  input  logic            pay_valid,
  output logic            pay_ready,
  input  logic [DATA-1:0] pay_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic            rd_last,
  output logic [DATA-1:0] wdata,
  output logic            wr,
  input  logic            full,
  input  logic [DATA-1:0] rdata,
  output logic            rd,
  input  logic            empty,
  output logic [15:0]     len,
  output logic            op,
  output logic            work,
  input  logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [15:0] HDR_N = 16'(HDR_BYTES);
  localparam logic [15:0] MAX_N = 16'(FIFO_DEPTH - HDR_BYTES);

  state_t      state;
  logic [15:0] addr_q;
  logic [4:0]  bsb_q;
  logic        wr_q;
  logic [15:0] n_q;
  logic [15:0] cnt;
  logic        pend;
  logic [15:0] pend_idx;

  logic [15:0] total;
  logic        hdr_push, pay_push, pad_push, pend_out, slot_free;

  assign total     = n_q + HDR_N;
  assign hdr_push  = (state == ST_HDR) && !full;
  assign pay_push  = (state == ST_PAY) && (wr_q == OP_WRITE) && pay_valid && !full;
  assign pad_push  = (state == ST_PAY) && (wr_q == OP_READ) && !full;
  assign pay_ready = pay_push;
  assign wr        = hdr_push || pay_push || pad_push;

  // A read byte landing this cycle occupies the output register, so no new RX read may chase it
  assign pend_out  = pend && (wr_q == OP_READ) && (pend_idx >= HDR_N);
  assign slot_free = (!rd_valid || rd_ready) && !pend_out;
  assign rd        = (state == ST_DRAIN) && (cnt < total) && !empty && slot_free;

  always_comb begin
    wdata = '0;
    if (state == ST_HDR) begin
      case (cnt[1:0])
        2'd0:    wdata = addr_q[15:8];
        2'd1:    wdata = addr_q[7:0];
        default: wdata = ctrl_byte(bsb_q, wr_q);
      endcase
    end else if (pay_push) begin
      wdata = pay_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      addr_q    <= '0;
      bsb_q     <= '0;
      wr_q      <= 1'b0;
      n_q       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      len       <= '0;
      op        <= 1'b0;
      work      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      work     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pend     <= rd;
      pend_idx <= cnt;
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
      if (pend_out) begin
        rd_valid <= 1'b1;
        rd_data  <= rdata;
        rd_last  <= (pend_idx == total - 16'd1);
      end
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            bsb_q     <= req_bsb;
            wr_q      <= req_write;
            n_q       <= req_len;
            req_ready <= 1'b0;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          cnt <= '0;
          if (n_q == 16'd0 || n_q > MAX_N) begin
            err       <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hdr_push) begin
            if (cnt == 16'd2) begin
              cnt   <= '0;
              state <= ST_PAY;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_PAY: begin
          if (pay_push || pad_push) begin
            if (cnt == n_q - 16'd1) begin
              cnt   <= '0;
              work  <= 1'b1;
              len   <= total;
              op    <= wr_q;
              state <= ST_START;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_START:   state <= ST_WAIT_HI;
        ST_WAIT_HI: if (busy) state <= ST_WAIT_LO;
        ST_WAIT_LO: if (!busy) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (rd) cnt <= cnt + 16'd1;
          if (wr_q == OP_WRITE) begin
            if (pend && pend_idx == total - 16'd1) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else if (rd_valid && rd_ready && rd_last) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          len       <= '0;
          op        <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w5500_frame_ctrl.sv
// tb/tb_w5500_frame_ctrl.sv - randomized scoreboard bench with FIFO and spi_interface models
module tb_w5500_frame_ctrl;

  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_len;
  logic [4:0]  req_bsb;
  logic        pay_valid, pay_ready;
  logic [7:0]  pay_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [7:0]  rd_data;
  logic [7:0]  wdata, rdata;
  logic        wr, full, rd, empty;
  logic [15:0] len;
  logic        op, work, busy, done, err;

  always #5 clk = ~clk;

  w5500_frame_ctrl #(.DATA(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_bsb(req_bsb),
    .req_write(req_write), .req_len(req_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wdata(wdata), .wr(wr), .full(full),
    .rdata(rdata), .rd(rd), .empty(empty),
    .len(len), .op(op), .work(work), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_tx[$];
  logic [8:0]  exp_rd[$];
  logic [16:0] exp_work[$];
  logic        exp_evt[$];
  logic [7:0]  txf[$], rxf[$], payq[$], rx_override[$], dir_pay[$];

  int          spi_st = 0, spi_cnt = 0;
  logic [15:0] spi_len;
  logic        spi_op;
  int          full_hold = 0, rdr_lo = 0;
  logic        rd_hold_arm = 1'b0;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_pend_data;
  logic        prev_hold = 1'b0, prev_last;
  logic [7:0]  prev_data;
  int          evt_seen = 0, evt_tgt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  task automatic drive();
    if (full_hold > 0) begin
      full = 1'b1; full_hold--;
    end else if (txf.size() >= FD) begin
      full = 1'b1;
    end else if ($urandom % 8 == 0) begin
      full = 1'b1; full_hold = 2;
    end else begin
      full = 1'b0;
    end
    if (rd_pend) begin
      rdata = rd_pend_data; rd_pend = 1'b0;
    end else begin
      rdata = 8'($urandom);
    end
    if (payq.size() > 0 && $urandom % 4 != 0) begin
      pay_valid = 1'b1; pay_data = payq[0];
    end else begin
      pay_valid = 1'b0; pay_data = 8'($urandom);
    end
    if (rdr_lo > 0) begin
      rd_ready = 1'b0; rdr_lo--;
    end else begin
      rd_ready = ($urandom % 4 != 0);
    end
    if (spi_st == 1) begin
      if (spi_cnt == 0) begin
        check("spi_tx_count", 32'(txf.size()), 32'(spi_len));
        txf.delete();
        for (int i = 0; i < int'(spi_len); i++) begin
          logic [7:0] b;
          b = (rx_override.size() > 0) ? rx_override.pop_front() : 8'($urandom);
          rxf.push_back(b);
          if (!spi_op && i >= 3) exp_rd.push_back({(i == int'(spi_len) - 1), b});
        end
        busy = 1'b1; spi_st = 2; spi_cnt = int'(spi_len) + int'($urandom % 3);
      end else begin
        spi_cnt--;
      end
    end else if (spi_st == 2) begin
      if (spi_cnt == 0) begin
        busy = 1'b0; spi_st = 0;
      end else begin
        spi_cnt--;
      end
    end
    empty = (rxf.size() == 0);
  endtask

  task automatic sample();
    if (wr) begin
      check("wr_while_full", 32'(full), 32'd0);
      if (exp_tx.size() == 0) fail_now("tx_unexpected");
      else check("tx_byte", 32'(wdata), 32'(exp_tx.pop_front()));
      txf.push_back(wdata);
    end
    if (pay_ready) begin
      check("pay_ready_valid", 32'(pay_valid), 32'd1);
      if (payq.size() > 0) void'(payq.pop_front());
    end
    if (rd) begin
      if (rxf.size() == 0) fail_now("rx_overread");
      else begin
        rd_pend = 1'b1; rd_pend_data = rxf.pop_front();
      end
    end
    if (work) begin
      if (exp_work.size() == 0) fail_now("work_unexpected");
      else check("work_len_op", 32'({op, len}), 32'(exp_work.pop_front()));
      spi_st = 1; spi_len = len; spi_op = op; spi_cnt = int'($urandom % 3);
    end
    if (prev_hold) check("rd_hold", 32'({rd_valid, rd_last, rd_data}), 32'({1'b1, prev_last, prev_data}));
    if (rd_valid && rd_hold_arm) begin
      rdr_lo = 4; rd_hold_arm = 1'b0;
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) fail_now("rd_unexpected");
      else check("rd_byte", 32'({rd_last, rd_data}), 32'(exp_rd.pop_front()));
    end
    prev_hold = rd_valid && !rd_ready;
    prev_data = rd_data;
    prev_last = rd_last;
    if (done || err) begin
      if (exp_evt.size() == 0) fail_now("event_unexpected");
      else check("event_kind", 32'({done, err}), exp_evt.pop_front() ? 32'd2 : 32'd1);
      if (done) begin
        check("rd_left", 32'(exp_rd.size()), 32'd0);
        check("rx_left", 32'(rxf.size()) + 32'(rd_pend), 32'd0);
        check("tx_left", 32'(exp_tx.size()), 32'd0);
      end
      evt_seen++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        drive();
        #4;
        if (rst) sample();
      end
    end
  end

  task automatic issue_req(input logic [15:0] a, input logic [4:0] b, input logic w, input logic [15:0] n);
    int  k;
    logic acc;
    if (n == 16'd0 || n > 16'(FD - 3)) begin
      exp_evt.push_back(1'b0);
    end else begin
      exp_tx.push_back(a[15:8]);
      exp_tx.push_back(a[7:0]);
      exp_tx.push_back({b, w, 2'b00});
      for (int i = 0; i < int'(n); i++) begin
        logic [7:0] p;
        if (w) p = (dir_pay.size() > 0) ? dir_pay.pop_front() : 8'($urandom);
        else   p = 8'h00;
        exp_tx.push_back(p);
        if (w) payq.push_back(p);
      end
      exp_work.push_back({w, n + 16'd3});
      exp_evt.push_back(1'b1);
    end
    evt_tgt = evt_seen + 1;
    @(negedge clk);
    req_addr = a; req_bsb = b; req_write = w; req_len = n; req_valid = 1'b1;
    k = 0; acc = 1'b0;
    while (!acc && k < 60) begin
      #4;
      if (req_ready) acc = 1'b1;
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    req_addr = 16'($urandom); req_bsb = 5'($urandom); req_write = 1'($urandom); req_len = 16'($urandom);
    if (!acc) fail_now("req_accept_timeout");
  endtask

  task automatic wait_evt();
    int k;
    k = 0;
    while (evt_seen < evt_tgt && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (evt_seen < evt_tgt) fail_now("completion_timeout");
    else begin
      #4;
      check("req_ready_back", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [4:0] b, input logic w, input logic [15:0] n);
    issue_req(a, b, w, n);
    wait_evt();
  endtask

  initial begin
    int k;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_bsb = '0; req_write = 1'b0; req_len = '0;
    pay_valid = 1'b0; pay_data = '0; rd_ready = 1'b0; rdata = '0; full = 1'b0; empty = 1'b1; busy = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("reset_ctrl", 32'({req_ready, pay_ready, rd_valid, rd_last, wr, rd, work, done, err, op}), 32'd0);
    check("reset_data", 32'({len, rd_data, wdata}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #4;
    check("req_ready_after_reset", 32'(req_ready), 32'd1);

    dir_pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run(16'h0001, 5'd0, 1'b1, 16'd4);
    rx_override = '{8'h11, 8'h22, 8'h33, 8'h04};
    run(16'h0039, 5'd0, 1'b0, 16'd1);
    run(16'h1234, 5'd3, 1'b1, 16'd0);
    run(16'h4321, 5'd1, 1'b0, 16'd6);
    rd_hold_arm = 1'b1;
    run(16'h0400, 5'd2, 1'b0, 16'd5);

    for (int i = 0; i < 40; i++) begin
      run(16'($urandom), 5'($urandom), 1'($urandom), 16'($urandom_range(0, 6)));
    end

    issue_req(16'h0100, 5'd4, 1'b0, 16'd3);
    k = 0;
    while (!busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!busy) fail_now("busy_timeout");
    @(negedge clk);
    #2 rst = 1'b0;
    exp_tx.delete(); exp_rd.delete(); exp_work.delete(); exp_evt.delete();
    txf.delete(); rxf.delete(); payq.delete(); rx_override.delete();
    spi_st = 0; busy = 1'b0; full_hold = 0; rdr_lo = 0; rd_pend = 1'b0; prev_hold = 1'b0;
    full = 1'b0; empty = 1'b1; pay_valid = 1'b0;
    #1;
    check("midop_reset_ctrl", 32'({req_ready, pay_ready, rd_valid, rd_last, wr, rd, work, done, err, op}), 32'd0);
    check("midop_reset_len", 32'(len), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    evt_seen = 0;
    run(16'h0102, 5'd5, 1'b1, 16'd5);
    run(16'h0203, 5'd6, 1'b0, 16'd2);

    check("exp_evt_empty", 32'(exp_evt.size()), 32'd0);
    check("exp_tx_empty", 32'(exp_tx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    fail_now("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
